// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction-fetch control block.
// Alignment checking on redirects is enabled by defining BUSCA_VERIFICA_ALINHAMENTO_EN.
package busca_pkg;

   localparam int          WORD_W   = 32;
   localparam logic [31:0] PC_PASSO = 32'd4;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      BUSCA  = 2'd1,
      PARADO = 2'd2
   } estado_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instrucao;
   } entrada_t;

endpackage

// File: rtl/fila_busca.sv
// Two-entry {pc, instrucao} queue between fetch and decode; entry 0 is always the head.
module fila_busca
   import busca_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] din_pc,
   input  logic [31:0] din_instrucao,
   output logic [1:0]  count,
   output logic [31:0] head_pc,
   output logic [31:0] head_instrucao
);

   entrada_t ent0_q, ent0_d;
   entrada_t ent1_q, ent1_d;
   logic [1:0] count_q, count_d;
   entrada_t nova;
   logic pop_ef, push_ef;

   assign nova    = '{pc: din_pc, instrucao: din_instrucao};
   assign pop_ef  = pop && (count_q != 2'd0);
   assign push_ef = push && ((count_q != 2'd2) || pop_ef);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else if (push_ef && pop_ef) begin
         if (count_q == 2'd1) begin
            ent0_d = nova;
         end else begin
            ent0_d = ent1_q;
            ent1_d = nova;
         end
      end else if (push_ef) begin
         if (count_q == 2'd0) ent0_d = nova;
         else                 ent1_d = nova;
         count_d = count_q + 2'd1;
      end else if (pop_ef) begin
         ent0_d  = ent1_q;
         count_d = count_q - 2'd1;
      end
   end

   // NOTE: the storage is reset too, because decode must see zeros on the head before the first push.
   always_ff @(posedge clk) begin
      if (reset) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign count          = count_q;
   assign head_pc        = ent0_q.pc;
   assign head_instrucao = ent0_q.instrucao;

endmodule

// File: rtl/controle_busca.sv
// Fetch control: OCIOSO/BUSCA/PARADO sequencing, PC generation, redirects and decode handshake.
// Define BUSCA_VERIFICA_ALINHAMENTO_EN to trap misaligned redirect targets.
module controle_busca
   import busca_pkg::*;
#(
   parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        habilita,
   input  logic        parar,
   input  logic        desvio_valido,
   input  logic [31:0] desvio_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instrucao,
   output logic        saida_valida,
   input  logic        saida_pronta,
   output logic [31:0] saida_instrucao,
   output logic [31:0] saida_pc,
   output logic [31:0] contador_instr,
   output logic        erro_alinhamento
);

   estado_t     estado_q, estado_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cont_q, cont_d;
   logic        erro_q, erro_d;

   logic [1:0]  fila_count;
   logic        desvio, desalinhado, push, pop;

`ifdef BUSCA_VERIFICA_ALINHAMENTO_EN
   assign desalinhado = (desvio_pc[1:0] != 2'b00);
`else
   assign desalinhado = 1'b0;
`endif

   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      cont_d   = cont_q;
      erro_d   = erro_q;

      // A redirect owns the cycle: no push, and a pending pop is neither taken nor counted.
      desvio = desvio_valido && (estado_q != PARADO);
      pop    = (fila_count != 2'd0) && saida_pronta && !desvio;
      push   = (estado_q == BUSCA) && !desvio && ((fila_count != 2'd2) || pop);

      if (pop)  cont_d = cont_q + 32'd1;
      if (push) pc_d   = pc_q + PC_PASSO;

      if (desvio && desalinhado) begin
         erro_d   = 1'b1;
         estado_d = PARADO;
      end else begin
         if (desvio) pc_d = desvio_pc & ~32'd3;
         case (estado_q)
            OCIOSO:  if (habilita) estado_d = BUSCA;
            BUSCA:   if (parar)    estado_d = PARADO;
            default: estado_d = estado_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= OCIOSO;
         pc_q     <= PC_INICIAL;
         cont_q   <= 32'd0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         cont_q   <= cont_d;
         erro_q   <= erro_d;
      end
   end

   fila_busca u_fila (
      .clk            (clk),
      .reset          (reset),
      .push           (push),
      .pop            (pop),
      .flush          (desvio),
      .din_pc         (pc_q),
      .din_instrucao  (imem_instrucao),
      .count          (fila_count),
      .head_pc        (saida_pc),
      .head_instrucao (saida_instrucao)
   );

   assign imem_addr        = pc_q;
   assign saida_valida     = (fila_count != 2'd0);
   assign contador_instr   = cont_q;
   assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_controle_busca.sv
// Scoreboard bench for controle_busca: reference model predicts deliveries, monitor checks them.
module tb_controle_busca;

   logic        clk = 1'b0;
   logic        reset, habilita, parar, desvio_valido, saida_pronta;
   logic [31:0] desvio_pc;
   logic [31:0] imem_addr, imem_instrucao, saida_instrucao, saida_pc, contador_instr;
   logic        saida_valida, erro_alinhamento;

   logic [31:0] d2_addr, d2_instr, d2_saida_instr, d2_saida_pc, d2_cont;
   logic        d2_valida, d2_erro;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   assign imem_instrucao = mem[imem_addr[11:2]];
   assign d2_instr       = mem[d2_addr[11:2]];

   controle_busca dut (
      .clk(clk), .reset(reset), .habilita(habilita), .parar(parar),
      .desvio_valido(desvio_valido), .desvio_pc(desvio_pc),
      .imem_addr(imem_addr), .imem_instrucao(imem_instrucao),
      .saida_valida(saida_valida), .saida_pronta(saida_pronta),
      .saida_instrucao(saida_instrucao), .saida_pc(saida_pc),
      .contador_instr(contador_instr), .erro_alinhamento(erro_alinhamento)
   );

   controle_busca #(.PC_INICIAL(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset), .habilita(habilita), .parar(1'b0),
      .desvio_valido(1'b0), .desvio_pc(32'd0),
      .imem_addr(d2_addr), .imem_instrucao(d2_instr),
      .saida_valida(d2_valida), .saida_pronta(1'b1),
      .saida_instrucao(d2_saida_instr), .saida_pc(d2_saida_pc),
      .contador_instr(d2_cont), .erro_alinhamento(d2_erro)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   item_t       m_fifo[$];
   item_t       exp_q[$];
   logic [31:0] m_pc  = 32'h0;
   logic [31:0] m_cnt = 32'h0;
   bit          m_err = 0, m_fetching = 0, m_halted = 0;

   bit          s_valid, s_err, s_halted;
   logic [31:0] s_cnt, s_pc;
   item_t       s_head;

   always @(negedge clk) begin : model
      bit redir, misal, pop, push;
      s_valid  = m_fifo.size() > 0;
      s_cnt    = m_cnt;
      s_err    = m_err;
      s_pc     = m_pc;
      s_halted = m_halted;
      if (s_valid) s_head = m_fifo[0];

      if (reset) begin
         m_fifo.delete();
         m_pc = 32'h0; m_cnt = 0; m_err = 0; m_fetching = 0; m_halted = 0;
      end else begin
         redir = desvio_valido && !m_halted;
`ifdef BUSCA_VERIFICA_ALINHAMENTO_EN
         misal = desvio_pc[1:0] != 2'b00;
`else
         misal = 1'b0;
`endif
         if (redir) begin
            m_fifo.delete();
            if (!misal) m_pc = {desvio_pc[31:2], 2'b00};
         end else begin
            pop  = m_fifo.size() > 0 && saida_pronta;
            push = m_fetching && (m_fifo.size() < 2 || pop);
            if (pop) begin
               exp_q.push_back(m_fifo.pop_front());
               m_cnt = m_cnt + 1;
            end
            if (push) begin
               m_fifo.push_back('{pc: m_pc, instr: mem[m_pc[11:2]]});
               m_pc = m_pc + 4;
            end
         end
         if (redir && misal) begin
            m_err = 1; m_halted = 1; m_fetching = 0;
         end else if (m_fetching && parar) begin
            m_halted = 1; m_fetching = 0;
         end else if (!m_fetching && !m_halted && habilita) begin
            m_fetching = 1;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      item_t e;
      #1;
      check("valida", saida_valida, s_valid);
      check("contador", contador_instr, s_cnt);
      check("erro", erro_alinhamento, s_err);
      check("imem_addr", imem_addr, s_pc);
      if (s_valid) begin
         check("head_pc", saida_pc, s_head.pc);
         check("head_instr", saida_instrucao, s_head.instr);
      end
      if (saida_valida && saida_pronta && !reset && !(desvio_valido && !s_halted)) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL delivery actual=pc %h expected=none", saida_pc);
         end else begin
            e = exp_q.pop_front();
            check("deliv_pc", saida_pc, e.pc);
            check("deliv_instr", saida_instrucao, e.instr);
         end
      end
   end

   // ---------------- PC wrap instance ----------------
   initial begin : wrap_chk
      logic [31:0] wrap_exp [3];
      int n;
      wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      n = 0;
      @(negedge reset);
      @(negedge clk); #1;
      while (!d2_valida && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("wrap_valid", d2_valida, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("wrap_pc", d2_saida_pc, wrap_exp[i]);
         check("wrap_instr", d2_saida_instr, mem[wrap_exp[i][11:2]]);
         @(negedge clk); #1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : stim
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

      reset = 1; habilita = 0; parar = 0; desvio_valido = 0; desvio_pc = 0; saida_pronta = 0;
      step(2);
      check("rst_pc", saida_pc, 32'h0);
      check("rst_instr", saida_instrucao, 32'h0);
      check("rst_valid", saida_valida, 1'b0);

      // straight-line fetch
      reset = 0; habilita = 1; saida_pronta = 1;
      step(1);
      habilita = 0;
      step(6);
      // backpressure saturates the queue
      saida_pronta = 0;
      step(5);
      saida_pronta = 1;
      step(4);
      // redirect with two buffered entries
      saida_pronta = 0;
      step(3);
      desvio_valido = 1; desvio_pc = 32'h100; saida_pronta = 1;
      step(1);
      desvio_valido = 0;
      step(4);
      // halt with two buffered entries, then mid-run reset
      saida_pronta = 0;
      step(3);
      parar = 1;
      step(1);
      parar = 0; saida_pronta = 1;
      step(5);
      reset = 1;
      step(1);
      reset = 0; habilita = 1;
      step(1);
      habilita = 0;
      step(3);
      // misaligned redirect target
      desvio_valido = 1; desvio_pc = 32'h102;
      step(1);
      desvio_valido = 0;
      step(4);
      reset = 1;
      step(1);
      reset = 0;

      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 99) == 0);
         habilita      = ($urandom_range(0, 3) == 0);
         parar         = ($urandom_range(0, 39) == 0);
         desvio_valido = ($urandom_range(0, 9) == 0);
         desvio_pc     = $urandom;
         if ($urandom_range(0, 3) != 0) desvio_pc[1:0] = 2'b00;
         saida_pronta  = ($urandom_range(0, 2) != 0);
         step(1);
      end

      reset = 0; parar = 0; desvio_valido = 0; saida_pronta = 1; habilita = 0;
      step(3);
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
